// File: rtl/cpu_types_pkg.sv
// Shared types for the instruction cache: frame entry layout, FSM states
// and the tag helper used by both the lookup and fill paths.
package cpu_types_pkg;

  localparam int FRAMES_DEFAULT = 16;
  localparam int WORD_W         = 32;
  // Widest tag needed: 32 address bits minus 2 offset bits minus at least 1 index bit.
  localparam int TAG_MAX_W      = 29;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MISS = 1'b1
  } icache_state_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [WORD_W-1:0]    data;
  } icache_frame_t;

  // Tag is everything above the index field, zero-extended to TAG_MAX_W.
  function automatic logic [TAG_MAX_W-1:0] tag_of(input logic [31:0] addr, input int idx_w);
    logic [31:0] shifted;
    shifted = addr >> (idx_w + 2);
    return shifted[TAG_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/icache_if.sv
// Datapath-side and memory-side signals of the instruction cache, plus its
// performance counters.
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr, hit_count, miss_count
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr, hit_count, miss_count
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one-word frames, a two-state
// miss FSM and saturating hit/miss counters.
module icache
  import cpu_types_pkg::*;
#(
  parameter int FRAMES = FRAMES_DEFAULT
) (
  input  logic     CLK,
  input  logic     nRST,
  icache_if.slave  bus
);

  localparam int IDX_W = $clog2(FRAMES);

  icache_frame_t        frame_reg [FRAMES];
  icache_state_t        state_reg;
  logic [31:0]          miss_addr_reg;
  logic [31:0]          iaddr_reg;
  logic                 iren_reg;
  logic [31:0]          hit_count_reg;
  logic [31:0]          miss_count_reg;

  logic [IDX_W-1:0]     req_idx;
  logic [IDX_W-1:0]     fill_idx;
  logic [TAG_MAX_W-1:0] req_tag;
  logic [TAG_MAX_W-1:0] fill_tag;
  icache_frame_t        req_frame;
  icache_frame_t        fill_frame;
  logic                 hit;
  logic                 fill;
  logic [FRAMES-1:0]    frame_we;

  assign req_idx   = bus.imemaddr[IDX_W+1:2];
  assign req_tag   = tag_of(bus.imemaddr, IDX_W);
  assign fill_idx  = miss_addr_reg[IDX_W+1:2];
  assign fill_tag  = tag_of(miss_addr_reg, IDX_W);
  assign req_frame = frame_reg[req_idx];

  // Lookup is purely combinational so a resident word returns in the request cycle.
  assign hit  = (state_reg == IDLE) && bus.imemREN && req_frame.valid &&
                (req_frame.tag == req_tag);
  assign fill = (state_reg == MISS) && !bus.iwait;

  assign fill_frame = '{valid: 1'b1, tag: fill_tag, data: bus.iload};

  genvar gi;
  generate
    for (gi = 0; gi < FRAMES; gi++) begin : g_we
      assign frame_we[gi] = fill && (fill_idx == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < FRAMES; i++) begin
        frame_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < FRAMES; i++) begin
        if (frame_we[i]) begin
          frame_reg[i] <= fill_frame;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg      <= IDLE;
      miss_addr_reg  <= '0;
      iaddr_reg      <= '0;
      iren_reg       <= 1'b0;
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      if (hit && (hit_count_reg != 32'hFFFF_FFFF)) begin
        hit_count_reg <= hit_count_reg + 32'd1;
      end
      case (state_reg)
        IDLE: begin
          if (bus.imemREN && !hit) begin
            state_reg     <= MISS;
            miss_addr_reg <= bus.imemaddr;
            iaddr_reg     <= bus.imemaddr;
            iren_reg      <= 1'b1;
            if (miss_count_reg != 32'hFFFF_FFFF) begin
              miss_count_reg <= miss_count_reg + 32'd1;
            end
          end
        end
        MISS: begin
          // The fill finishes regardless of what the datapath does meanwhile.
          if (!bus.iwait) begin
            state_reg <= IDLE;
            iaddr_reg <= '0;
            iren_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          iaddr_reg <= '0;
          iren_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ihit       = hit;
  assign bus.imemload   = hit ? req_frame.data : '0;
  assign bus.iREN       = iren_reg;
  assign bus.iaddr      = iaddr_reg;
  assign bus.hit_count  = hit_count_reg;
  assign bus.miss_count = miss_count_reg;

endmodule
